// File: rtl/encode_nivel_cxa.sv
// Tank-level encoder: three float switches -> 2-bit level code Nv1/Nv0.
// Each switch is synchronised (2 flops) and debounced. The level steps one
// code per clock toward the sensed target. Invalid (non-thermometer)
// combinations raise ERRO and freeze the level.
// Optional: define ERR_LATCH_EN to make ERRO sticky until RST.

// Per-sensor synchroniser + debounce filter
module encode_nivel_cxa_deb #(
    parameter int DEB_CYCLES = 16,
    parameter int DEB_W      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic filt
);
    logic [1:0]       sync;
    logic [DEB_W-1:0] cnt;

    // filt only follows sync after DEB_CYCLES consecutive differing cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            filt <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] != filt) begin
                if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
                    filt <= sync[1];
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module encode_nivel_cxa #(
    parameter int DEB_CYCLES = 16,
    parameter int DEB_W      = 5
) (
    input  logic CLK,
    input  logic RST,
    input  logic S_BAIXO,
    input  logic S_MEDIO,
    input  logic S_ALTO,
    output logic Nv1,
    output logic Nv0,
    output logic CHG,
    output logic ERRO
);
    localparam int NUM_SENS = 3;

    typedef enum logic [1:0] {
        VAZIO = 2'b00,
        BAIXO = 2'b01,
        MEDIO = 2'b10,
        CHEIO = 2'b11
    } lvl_t;

    // bit 0 = low, bit 1 = mid, bit 2 = high
    logic [NUM_SENS-1:0] sens;
    logic [NUM_SENS-1:0] filt;
    lvl_t                state, state_nxt, target;
    logic                invalid;
    logic                chg_q, erro_q;

    assign sens = {S_ALTO, S_MEDIO, S_BAIXO};

    genvar g;
    generate
        for (g = 0; g < NUM_SENS; g++) begin : g_deb
            encode_nivel_cxa_deb #(
                .DEB_CYCLES(DEB_CYCLES),
                .DEB_W     (DEB_W)
            ) u_deb (
                .clk (CLK),
                .rst (RST),
                .din (sens[g]),
                .filt(filt[g])
            );
        end
    endgenerate

    // Decode the filtered thermometer code and pick the next level (one step max)
    always_comb begin
        invalid   = 1'b0;
        target    = state;
        state_nxt = state;
        case (filt)
            3'b000:  target = VAZIO;
            3'b001:  target = BAIXO;
            3'b011:  target = MEDIO;
            3'b111:  target = CHEIO;
            default: invalid = 1'b1;
        endcase
        if (!invalid) begin
            if (target > state)
                state_nxt = lvl_t'(state + 2'd1);
            else if (target < state)
                state_nxt = lvl_t'(state - 2'd1);
        end
    end

    // Level register, change pulse and error flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= VAZIO;
            chg_q  <= 1'b0;
            erro_q <= 1'b0;
        end else begin
            state <= state_nxt;
            chg_q <= (state_nxt != state);
`ifdef ERR_LATCH_EN
            erro_q <= erro_q | invalid;
`else
            erro_q <= invalid;
`endif
        end
    end

    assign Nv1  = state[1];
    assign Nv0  = state[0];
    assign CHG  = chg_q;
    assign ERRO = erro_q;
endmodule

// File: tb/tb_encode_nivel_cxa.sv
// Scoreboard bench for encode_nivel_cxa (DEB_CYCLES=4). Stimulus pushes the
// expected (edge, level, error) events; a monitor pops one whenever CHG
// pulses or ERRO toggles and compares.
module tb_encode_nivel_cxa;
    localparam int DEB = 4;

    logic CLK = 1'b0;
    logic RST;
    logic S_BAIXO, S_MEDIO, S_ALTO;
    logic Nv1, Nv0, CHG, ERRO;

    typedef struct {
        int         cyc;
        logic [1:0] nv;
        logic       erro;
    } ev_t;

    ev_t  q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic rst_seen = 1'b1;
    logic erro_prev = 1'b0;

`ifdef ERR_LATCH_EN
    localparam logic LATCH = 1'b1;
`else
    localparam logic LATCH = 1'b0;
`endif

    encode_nivel_cxa #(.DEB_CYCLES(DEB), .DEB_W(3)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .S_BAIXO(S_BAIXO),
        .S_MEDIO(S_MEDIO),
        .S_ALTO (S_ALTO),
        .Nv1    (Nv1),
        .Nv0    (Nv0),
        .CHG    (CHG),
        .ERRO   (ERRO)
    );

    always #5 CLK = ~CLK;

    // edge counter and reset sampled at that edge
    always @(posedge CLK) begin
        cyc      = cyc + 1;
        rst_seen = RST;
    end

    // monitor: every CHG pulse or ERRO toggle must match the next expected event
    always @(negedge CLK) begin
        if (!rst_seen && (CHG || ERRO != erro_prev)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL event: unexpected at edge %0d nv=%0d erro=%0b", cyc, {Nv1, Nv0}, ERRO);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (e.cyc != cyc || e.nv != {Nv1, Nv0} || e.erro != ERRO) begin
                    errors++;
                    $display("FAIL event: got edge %0d nv=%0d erro=%0b, expected edge %0d nv=%0d erro=%0b",
                             cyc, {Nv1, Nv0}, ERRO, e.cyc, e.nv, e.erro);
                end
            end
        end
        erro_prev = ERRO;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_in(input logic a, input logic m, input logic b);
        S_ALTO  = a;
        S_MEDIO = m;
        S_BAIXO = b;
    endtask

    task automatic expect_ev(input int off, input logic [1:0] nv, input logic er);
        ev_t e;
        e.cyc  = cyc + off;
        e.nv   = nv;
        e.erro = er;
        q.push_back(e);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_nv"},   {Nv1, Nv0}, 0);
        chk({name, "_chg"},  CHG, 0);
        chk({name, "_erro"}, ERRO, 0);
    endtask

    initial begin
        // 1: reset with all sensors high
        RST = 1'b1;
        set_in(1, 1, 1);
        tick(1);
        chk_idle("rst1");
        tick(1);
        chk_idle("rst2");
        RST = 1'b0;
        tick(1);
        chk_idle("rel");
        RST = 1'b1;
        set_in(0, 0, 0);
        tick(2);
        RST = 1'b0;

        // 2: clean rise of the low switch -> 01 at edge DEB+3
        set_in(0, 0, 1);
        expect_ev(DEB + 3, 2'd1, 1'b0);
        tick(DEB + 5);
        chk("rise_nv", {Nv1, Nv0}, 1);
        chk("rise_chg_after", CHG, 0);

        // 3: back to empty, then a 3-cycle glitch must be rejected
        set_in(0, 0, 0);
        expect_ev(DEB + 3, 2'd0, 1'b0);
        tick(10);
        set_in(0, 0, 1);
        tick(3);
        set_in(0, 0, 0);
        tick(12);
        chk("glitch_nv", {Nv1, Nv0}, 0);

        // 4: full swing up then down, one step per cycle
        set_in(1, 1, 1);
        expect_ev(DEB + 3, 2'd1, 1'b0);
        expect_ev(DEB + 4, 2'd2, 1'b0);
        expect_ev(DEB + 5, 2'd3, 1'b0);
        tick(12);
        chk("swing_up", {Nv1, Nv0}, 3);
        set_in(0, 0, 0);
        expect_ev(DEB + 3, 2'd2, 1'b0);
        expect_ev(DEB + 4, 2'd1, 1'b0);
        expect_ev(DEB + 5, 2'd0, 1'b0);
        tick(12);
        chk("swing_dn", {Nv1, Nv0}, 0);

        // 5: invalid 101 from level 01 freezes the level and raises ERRO
        set_in(0, 0, 1);
        expect_ev(DEB + 3, 2'd1, 1'b0);
        tick(10);
        set_in(1, 0, 1);
        expect_ev(DEB + 3, 2'd1, 1'b1);
        tick(10);
        chk("inv_nv", {Nv1, Nv0}, 1);
        chk("inv_erro", ERRO, 1);
        set_in(0, 0, 1);
        if (!LATCH) expect_ev(DEB + 3, 2'd1, 1'b0);
        tick(10);
        chk("inv_clr_erro", ERRO, int'(LATCH));
        chk("inv_clr_nv", {Nv1, Nv0}, 1);
        RST = 1'b1;
        set_in(0, 0, 0);
        tick(2);
        chk_idle("inv_rst");
        RST = 1'b0;

        // 6: reset mid-swing at level 10, then debounce restarts
        set_in(1, 1, 1);
        expect_ev(DEB + 3, 2'd1, 1'b0);
        expect_ev(DEB + 4, 2'd2, 1'b0);
        tick(DEB + 4);
        chk("mid_nv", {Nv1, Nv0}, 2);
        RST = 1'b1;
        tick(1);
        chk_idle("mid_rst");
        RST = 1'b0;
        expect_ev(DEB + 3, 2'd1, 1'b0);
        expect_ev(DEB + 4, 2'd2, 1'b0);
        expect_ev(DEB + 5, 2'd3, 1'b0);
        tick(12);
        chk("mid_again", {Nv1, Nv0}, 3);

        tick(2);
        chk("sb_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
